// File: rtl/fp_pkg.sv
// Shared IEEE-754 binary32/binary64 constants and types used by the
// narrowing and widening conversion stages.
package fp_pkg;

    localparam int unsigned EXP_W_32 = 8;
    localparam int unsigned MAN_W_32 = 23;
    localparam int unsigned EXP_W_64 = 11;
    localparam int unsigned MAN_W_64 = 52;

    localparam int unsigned EXP_BIAS_32 = 127;
    localparam int unsigned EXP_BIAS_64 = 1023;

    localparam logic [EXP_W_32-1:0] EXP_SPECIAL_32 = '1;
    localparam logic [EXP_W_64-1:0] EXP_SPECIAL_64 = '1;

    typedef enum logic [2:0] {
        ZERO,
        SUBNORMAL,
        NORMAL,
        INF,
        QNAN,
        SNAN
    } fp_class_e;

    typedef enum logic [2:0] {
        StIdle,
        StClassify,
        StAlign,
        StRound,
        StDone
    } d2f_state_e;

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even increment of a binary32 mantissa given guard and sticky.
module fp_round_rne
    import fp_pkg::*;
(
    input  logic [MAN_W_32-1:0] mant_i,
    input  logic                lsb_i,
    input  logic                g_i,
    input  logic                s_i,
    output logic [MAN_W_32-1:0] mant_o,
    output logic                carry_o,
    output logic                inexact_o
);

    logic round_up;

    assign round_up            = g_i & (s_i | lsb_i);
    assign {carry_o, mant_o}   = {1'b0, mant_i} + {{MAN_W_32{1'b0}}, round_up};
    assign inexact_o           = g_i | s_i;

endmodule

// File: rtl/double_to_float.sv
// Multi-cycle binary64 -> binary32 narrowing converter with RNE rounding,
// sticky exception flags and a fixed-latency start/done handshake.
module double_to_float
    import fp_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [63:0] double_i,
    output logic [31:0] float_o,
    output logic        done_o,
    output logic        busy_o,
    output logic        nan_exception_o,
    output logic        overflow_o,
    output logic        underflow_o,
    output logic        inexact_o
);

    localparam logic signed [11:0] Bias64 = 12'(EXP_BIAS_64);
    localparam logic signed [11:0] Bias32 = 12'(EXP_BIAS_32);

    d2f_state_e state_q, state_d;

    logic [63:0]          op_q;
    logic                 sign_q;
    logic [EXP_W_64-1:0]  e64_q;
    logic [MAN_W_64-1:0]  man_q;
    fp_class_e            cls_q, cls_d;
    logic                 big_q, tiny_q, g_q, s_q;
    logic [EXP_W_32-1:0]  exp_q;
    logic [MAN_W_32-1:0]  mant_q;
    logic [31:0]          float_q;
    logic                 done_q, busy_q, nan_q, ovf_q, uf_q, ix_q;

    // Align-stage combinational values
    logic signed [11:0]   e_unb, sh_full;
    logic [4:0]           sh;
    logic [54:0]          wide, mask;
    logic [51:0]          shifted;
    logic                 big_a, norm_a, g_a, s_a;
    logic [EXP_W_32-1:0]  exp_a;
    logic [MAN_W_32-1:0]  mant_a;

    // Round-stage combinational values
    logic [MAN_W_32-1:0]  mant_r;
    logic                 carry_r, inexact_r;
    logic [EXP_W_32-1:0]  exp_r;
    logic [31:0]          res_d;
    logic                 nan_d, ovf_d, uf_d, ix_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (start_i) state_d = StClassify;
            StClassify: state_d = StAlign;
            StAlign:    state_d = StRound;
            StRound:    state_d = StDone;
            StDone:     state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_comb begin
        cls_d = NORMAL;
        if (op_q[62:52] == EXP_SPECIAL_64) begin
            if (op_q[51:0] == '0) cls_d = INF;
            else if (op_q[51])    cls_d = QNAN;
            else                  cls_d = SNAN;
        end else if (op_q[62:52] == '0) begin
            cls_d = (op_q[51:0] == '0) ? ZERO : SUBNORMAL;
        end
    end

    always_comb begin
        e_unb   = $signed({1'b0, e64_q}) - Bias64;
        big_a   = e_unb > 12'sd127;
        norm_a  = e_unb >= -12'sd126;
        sh_full = -12'sd126 - e_unb;
        sh      = (sh_full > 12'sd25) ? 5'd25 : 5'(sh_full);
        wide    = {2'b00, 1'b1, man_q};
        shifted = 52'(wide >> sh);
        mask    = (55'd1 << sh) - 55'd1;
        if (norm_a) begin
            exp_a  = 8'(e_unb + Bias32);
            mant_a = man_q[51:29];
            g_a    = man_q[28];
            s_a    = |man_q[27:0];
        end else begin
            // Bits pushed out by the alignment shift still feed the sticky bit
            exp_a  = '0;
            mant_a = shifted[51:29];
            g_a    = shifted[28];
            s_a    = (|shifted[27:0]) | (|(wide & mask));
        end
    end

    fp_round_rne u_round (
        .mant_i    (mant_q),
        .lsb_i     (mant_q[0]),
        .g_i       (g_q),
        .s_i       (s_q),
        .mant_o    (mant_r),
        .carry_o   (carry_r),
        .inexact_o (inexact_r)
    );

    always_comb begin
        res_d = {sign_q, 31'b0};
        nan_d = 1'b0;
        ovf_d = 1'b0;
        uf_d  = 1'b0;
        ix_d  = 1'b0;
        // A subnormal result that carries into bit 23 lands on exponent 1
        exp_r = exp_q + {7'b0, carry_r};
        unique case (cls_q)
            ZERO: ;
            SUBNORMAL: begin
                uf_d = 1'b1;
                ix_d = 1'b1;
            end
            INF:  res_d = {sign_q, EXP_SPECIAL_32, 23'b0};
            QNAN: res_d = {sign_q, EXP_SPECIAL_32, man_q[51:29]};
            SNAN: begin
                res_d = {sign_q, EXP_SPECIAL_32, 1'b1, man_q[50:29]};
                nan_d = 1'b1;
            end
            NORMAL: begin
                if (big_q || exp_r == EXP_SPECIAL_32) begin
                    res_d = {sign_q, EXP_SPECIAL_32, 23'b0};
                    ovf_d = 1'b1;
                    ix_d  = 1'b1;
                end else begin
                    res_d = {sign_q, exp_r, mant_r};
                    ix_d  = inexact_r;
                    uf_d  = tiny_q & inexact_r;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_q    <= '0;
            sign_q  <= 1'b0;
            e64_q   <= '0;
            man_q   <= '0;
            cls_q   <= ZERO;
            big_q   <= 1'b0;
            tiny_q  <= 1'b0;
            g_q     <= 1'b0;
            s_q     <= 1'b0;
            exp_q   <= '0;
            mant_q  <= '0;
            float_q <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            nan_q   <= 1'b0;
            ovf_q   <= 1'b0;
            uf_q    <= 1'b0;
            ix_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        op_q   <= double_i;
                        busy_q <= 1'b1;
                        done_q <= 1'b0;
                        nan_q  <= 1'b0;
                        ovf_q  <= 1'b0;
                        uf_q   <= 1'b0;
                        ix_q   <= 1'b0;
                    end
                end
                StClassify: begin
                    sign_q <= op_q[63];
                    e64_q  <= op_q[62:52];
                    man_q  <= op_q[51:0];
                    cls_q  <= cls_d;
                end
                StAlign: begin
                    big_q  <= big_a;
                    tiny_q <= ~norm_a;
                    exp_q  <= exp_a;
                    mant_q <= mant_a;
                    g_q    <= g_a;
                    s_q    <= s_a;
                end
                StRound: begin
                    float_q <= res_d;
                    nan_q   <= nan_d;
                    ovf_q   <= ovf_d;
                    uf_q    <= uf_d;
                    ix_q    <= ix_d;
                end
                StDone: begin
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign float_o         = float_q;
    assign done_o          = done_q;
    assign busy_o          = busy_q;
    assign nan_exception_o = nan_q;
    assign overflow_o      = ovf_q;
    assign underflow_o     = uf_q;
    assign inexact_o       = ix_q;

endmodule

// File: doc/double_to_float.md
Name: double_to_float

Overview:
Multi-cycle IEEE-754 narrowing converter from binary64 to binary32. It is the return-path partner of the float-to-double widening stage and consumes doubles produced by the 64-bit datapath.
- Round-to-nearest-even.
- Produces signed zero, subnormal, infinity and quieted-NaN results.
- Raises sticky exception flags.
- Start/done handshake with fixed latency, so it can sit directly behind any 64-bit producer.

Parameters:
EXP_BIAS_32, 127, binary32 exponent bias
EXP_BIAS_64, 1023, binary64 exponent bias

Ports:
clk  input  1  rising-edge clock; single clock domain
reset  input  1  asynchronous, active-low reset
start  input  1  request pulse; sampled only when busy=0
double  input  64  operand; sampled on the accepting edge only
float  output  32  result; valid while done=1
done  output  1  result valid; held until the next start is accepted
busy  output  1  high from the accept edge until done rises
nan_exception  output  1  input was sNaN
overflow  output  1  finite input rounded beyond the binary32 maximum
underflow  output  1  result tiny before rounding and inexact
inexact  output  1  result differs from the input value

Behaviour:
- Reset (asynchronous, reset=0):
  - state=IDLE.
  - float, done, busy and all four flags go to 0 immediately, with no clock edge required.
- States:
  - IDLE: accept when start=1; latch double; clear done and flags; busy=1.
  - CLASSIFY: split the operand into sign, e64 and m[51:0]; decode its class.
  - ALIGN: compute the unbiased exponent, shift amount, guard bit and sticky bit.
  - ROUND: apply RNE and compose float and flags.
  - DONE: done=1, busy=0; go to IDLE in the same edge.
- Latency and handshake:
  - If start is accepted at edge N, done=1 after edge N+4.
  - Latency is fixed for every operand class; special values also pass through all states.
  - start while busy=1 is ignored.
  - start while done=1 is accepted: done drops after that edge and the flags clear.
- Classes (sign is always copied):
  - e64=0x7FF, m=0: ±inf, result 0x7F800000 with sign.
  - e64=0x7FF, m[51]=1 (qNaN): mantissa32 = m[51:29], exponent 0xFF.
  - e64=0x7FF, m[51]=0, m≠0 (sNaN): mantissa32 = {1'b1, m[50:29]}, exponent 0xFF, nan_exception=1.
  - e64=0: ±0. If m≠0, also set underflow=1 and inexact=1.
- Finite nonzero operand, e = e64 − EXP_BIAS_64:
  - e > 127: ±inf, overflow=1, inexact=1.
  - e ≥ −126 (normal path):
    - exp32 = e + 127; LSB = m[29], G = m[28], S = |m[27:0].
    - Round up when G & (S | LSB).
    - A mantissa carry increments exp32. If exp32 then reaches 255, the result is ±inf with overflow=1.
  - e < −126 (subnormal path):
    - sh = min(−126 − e, 25); F = {1, m} (53 bits).
    - f = F >> (29 + sh).
    - G = bit (28 + sh) of F; S = OR of all lower bits.
    - Compose {sign, 8'h00, f} and add the round increment. A carry into bit 23 correctly yields the minimum normal.
    - underflow = (G|S).
  - inexact = (G|S) on any finite path, and on the overflow path.
- Flags are sticky from DONE until the next accept or reset.
- Width rules:
  - Exponent arithmetic uses 12-bit signed values.
  - Shifts operate on a 55-bit field (F plus guard) with sticky reduction.
  - No truncation before rounding.

Decomposition:
- Shared package fp_pkg holds:
  - Width constants (EXP_W_32 = 8, MAN_W_32 = 23, EXP_W_64 = 11, MAN_W_64 = 52).
  - Both biases.
  - EXP_SPECIAL_32/64 all-ones constants.
  - An fp_class enum: ZERO, SUBNORMAL, NORMAL, INF, QNAN, SNAN. This package is shared with the widening stage.
- One sub-module, fp_round_rne:
  - Inputs: 23-bit mantissa, LSB, G, S.
  - Outputs: rounded mantissa, carry, inexact.
  - Purely combinational; instantiated in ROUND.

Test Plan:
1. 0x3FF0000000000000 → float 0x3F800000, all flags 0; done rises exactly 4 edges after the accept.
2. 0x3FF0000010000000 (tie, even LSB) → 0x3F800000 with inexact=1. 0x3FF0000030000000 (tie, odd LSB) → 0x3F800002 with inexact=1.
3. 0x47F0000000000000 → 0x7F800000 with overflow=1, inexact=1. 0x47EFFFFFF0000000 (rounding carry) → 0x7F800000 with overflow=1.
4. 0x36A0000000000000 (2^-149) → 0x00000001, flags 0. 0x3690000000000000 (2^-150) → 0x00000000 with underflow=1, inexact=1. 0x0000000000000001 → 0x00000000 with underflow=1.
5. 0x7FF4000000000000 → 0x7FE00000 with nan_exception=1. 0xFFF8000000000000 → 0xFFC00000 with nan_exception=0. 0xFFF0000000000000 → 0xFF800000, flags 0.
6. Handshake and reset:
   - Pulse start while busy → ignored; the first result is unchanged.
   - Drop reset during ALIGN → float, done, busy and flags read 0 before the next edge.
   - Release reset, then start with 1.0 → 0x3F800000 after 4 edges.
